// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, data-memory defaults, responder FSM
// state encoding and the captured request payload.
package cpu_pkg;

   localparam int unsigned DATA_W       = 64;
   localparam int unsigned ADDR_W       = 64;
   localparam int unsigned DMEM_DEPTH   = 64;
   localparam int unsigned DMEM_LATENCY = 2;
   localparam int unsigned CNT_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage for the data memory: one synchronous write port and one
// combinational read port. Contents are never reset.
module dmem_array
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = DMEM_DEPTH,
   parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_c = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory-access stage: accepts one load/store,
// waits LATENCY cycles, then holds the response until consumed.
// Optional: define DMEM_ALIGN_CHECK_EN to fault on addresses not 8-byte aligned.
module data_mem_responder
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH   = DMEM_DEPTH,
   parameter int unsigned LATENCY = DMEM_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int unsigned      IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH) << 3;
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);

   dmem_state_e       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   dmem_req_t         cap, cap_nxt;
   logic              rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic              fault_c, mem_we_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] mem_rdata_c;

   // Fault classification of the captured request
   always_comb begin
      fault_c = (cap.addr >= ADDR_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
      fault_c = fault_c | (cap.addr[2:0] != 3'b000);
`endif
      idx_c = cap.addr[3 +: IDX_W];
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_dmem_array (
      .clk     (clk),
      .we      (mem_we_c),
      .waddr   (idx_c),
      .wdata   (cap.wdata),
      .raddr   (idx_c),
      .rdata_c (mem_rdata_c)
   );

   // Next-state and response logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cap_nxt       = cap;
      rsp_valid_nxt = rsp_valid;
      rsp_err_nxt   = rsp_err;
      rsp_rdata_nxt = rsp_rdata;
      mem_we_c      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               cap_nxt.write = req_write;
               cap_nxt.addr  = req_addr;
               cap_nxt.wdata = req_wdata;
               cnt_nxt       = CNT_LOAD;
               state_nxt     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == '0) begin
               // The access itself happens on the edge leaving ACCESS
               mem_we_c      = cap.write & ~fault_c;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = fault_c;
               rsp_rdata_nxt = (cap.write || fault_c) ? '0 : mem_rdata_c;
               state_nxt     = ST_RESPOND;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_RESPOND: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               rsp_err_nxt   = 1'b0;
               state_nxt     = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cap       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cap       <= cap_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         req_ready <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against an array model
// of the doubleword memory and the request/response timing rules.
module tb_data_mem_responder;

   localparam int unsigned DEPTH   = 64;
   localparam int unsigned LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [63:0] rsp_rdata;

   logic [63:0] mem_model [DEPTH];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_fault(input logic [63:0] addr);
      logic f;
      f = (addr >= 64'(DEPTH) * 64'd8);
`ifdef DMEM_ALIGN_CHECK_EN
      if (addr[2:0] != 3'b000) f = 1'b1;
`endif
      return f;
   endfunction

   // One full transaction: accept, latency window, optional backpressure, handshake
   task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input int hold);
      logic        flt;
      logic [63:0] exp_rd;
      int          idx;
      flt    = is_fault(addr);
      idx    = int'(addr >> 3);
      exp_rd = (wr || flt) ? 64'd0 : mem_model[idx];
      if (wr && !flt) mem_model[idx] = wd;

      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
      check("idle_req_ready", req_ready, 1);
      check("idle_busy", busy, 0);
      @(posedge clk);
      for (int i = 0; i <= int'(LATENCY); i++) begin
         @(negedge clk);
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = {$urandom, $urandom};
         check("busy_high", busy, 1);
         check("req_ready_low", req_ready, 0);
         check("rsp_valid_latency", rsp_valid, (i == int'(LATENCY)) ? 1 : 0);
      end
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", rsp_err, flt);
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         req_valid = 1'b1;
         @(negedge clk);
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_rdata", rsp_rdata, exp_rd);
         check("hold_rsp_err", rsp_err, flt);
         check("hold_req_ready", req_ready, 0);
      end
      // Request stays asserted across the handshake edge: must not be taken
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      check("done_rsp_valid", rsp_valid, 0);
      check("done_rsp_err", rsp_err, 0);
      check("done_busy", busy, 0);
      check("done_req_ready", req_ready, 1);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
   endtask

   // Store that is abandoned by a reset while in ACCESS
   task automatic do_reset_in_access(input logic [63:0] addr, input logic [63:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic        wr;
      logic [63:0] addr, wd;
      int          sel;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_busy", busy, 0);
      check("reset_req_ready", req_ready, 1);
      rst_n = 1'b1;

      // Give every doubleword a known value
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_txn(1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 0);
      end

      do_txn(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
      do_txn(1'b0, 64'h10, 64'h0, 0);
      check("directed_load_0x10", mem_model[2], 64'hDEADBEEF_CAFEF00D);
      do_txn(1'b0, 64'h200, 64'h0, 0);
      do_txn(1'b0, 64'h0, 64'h0, 0);
      do_txn(1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 5);
      do_txn(1'b0, 64'h18, 64'h0, 5);
      do_reset_in_access(64'h08, 64'h1234);
      do_txn(1'b0, 64'h08, 64'h0, 0);
      do_txn(1'b0, 64'h0C, 64'h0, 0);
      do_txn(1'b1, 64'h0C, 64'h5555_AAAA_5555_AAAA, 0);
      do_txn(1'b0, 64'h08, 64'h0, 0);

      for (int n = 0; n < 150; n++) begin
         wr  = 1'($urandom_range(0, 1));
         wd  = {$urandom, $urandom};
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
         else if (sel < 8)  addr = 64'($urandom_range(0, DEPTH * 8 - 1));
         else if (sel == 8) addr = 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 64));
         else               addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         do_txn(wr, addr, wd, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
